// File: rtl/rowbias_sequencer_if.sv
// Control/bring-up bus between solver control and the rowbias sequencer.
// master: solver-side controller (drives start/seed, observes status).
// slave : the sequencer itself.
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

interface rowbias_sequencer_if #(
  parameter int NUM_ROWS   = `GRID_LEN,
  parameter int RAND_WIDTH = 16
);
  logic                  start;
  logic [15:0]           seed;
  logic [NUM_ROWS-1:0]   rb_reset;
  logic [RAND_WIDTH-1:0] random;
  logic                  busy;
  logic                  done;

  modport master (output start, seed, input rb_reset, random, busy, done);
  modport slave  (input start, seed, output rb_reset, random, busy, done);
endinterface

// File: rtl/rowbias_sequencer.sv
// rowbias_sequencer: holds every rowbias instance in reset, then releases
// them one row at a time, SETTLE_CYCLES apart, while a 16-bit Galois LFSR
// drives the shared random bus.
// Optional build macro: ROWBIAS_SEQUENCER_FREERUN_EN
//   defined   -> LFSR free-runs in IDLE/DONE, seed is XORed in on start.
//   undefined -> LFSR holds in IDLE/DONE, seed replaces it (repeatable).
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | after reset; all rows held in reset, waiting for start
// LOAD    | one cycle; all rows in reset, row/count initialised
// RELEASE | rows 0..row released, count settles the current row
// DONE    | all rows released; waiting for a restart
`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module rowbias_sequencer #(
  parameter int NUM_ROWS      = `GRID_LEN,
  parameter int WIDTH         = `GRID_LEN,
  parameter int RAND_WIDTH    = 16,
  parameter int SETTLE_CYCLES = 2*WIDTH+2
) (
  input  logic                 clock,
  input  logic                 reset,
  rowbias_sequencer_if.slave   bus
);

  localparam int ROW_W = $clog2((NUM_ROWS < 2) ? 2 : NUM_ROWS);
  localparam int CNT_W = $clog2((SETTLE_CYCLES < 2) ? 2 : SETTLE_CYCLES);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(NUM_ROWS-1);
  localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES-1);
  localparam logic [15:0]      LFSR_INIT = 16'hACE1;

  typedef enum logic [3:0] {
    IDLE    = 4'b0001,
    LOAD    = 4'b0010,
    RELEASE = 4'b0100,
    DONE    = 4'b1000
  } state_t;

  state_t           state;
  logic [15:0]      lfsr;
  logic [ROW_W-1:0] row;
  logic [CNT_W-1:0] count;

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  // The zero state would lock the LFSR, so it is always replaced.
  function automatic logic [15:0] reseed(input logic [15:0] cur, input logic [15:0] s);
    logic [15:0] v;
`ifdef ROWBIAS_SEQUENCER_FREERUN_EN
    v = cur ^ s;
`else
    v = s;
    if (cur == 16'h0) v = s;
`endif
    return (v == 16'h0) ? LFSR_INIT : v;
  endfunction

  // Rows above r stay in reset; rows 0..r are released.
  function automatic logic [NUM_ROWS-1:0] hold_mask(input logic [ROW_W-1:0] r);
    logic [NUM_ROWS-1:0] m;
    for (int j = 0; j < NUM_ROWS; j++) m[j] = (j > int'(r));
    return m;
  endfunction

  assign bus.random = lfsr[RAND_WIDTH-1:0];

  // Sequencer FSM with registered rb_reset/busy/done.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      lfsr         <= LFSR_INIT;
      row          <= '0;
      count        <= '0;
      bus.rb_reset <= '1;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (bus.start) begin
            state        <= LOAD;
            lfsr         <= reseed(lfsr, bus.seed);
            bus.rb_reset <= '1;
            bus.busy     <= 1'b1;
            bus.done     <= 1'b0;
          end
`ifdef ROWBIAS_SEQUENCER_FREERUN_EN
          else begin
            lfsr <= lfsr_step(lfsr);
          end
`endif
        end
        LOAD: begin
          state        <= RELEASE;
          row          <= '0;
          count        <= RELOAD;
          bus.rb_reset <= hold_mask('0);
        end
        RELEASE: begin
          lfsr <= lfsr_step(lfsr);
          if (count == '0) begin
            if (row == LAST_ROW) begin
              state        <= DONE;
              bus.rb_reset <= '0;
              bus.busy     <= 1'b0;
              bus.done     <= 1'b1;
            end else begin
              row          <= row + 1'b1;
              count        <= RELOAD;
              bus.rb_reset <= hold_mask(row + 1'b1);
            end
          end else begin
            count <= count - 1'b1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.rb_reset <= '1;
          bus.busy     <= 1'b0;
          bus.done     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rowbias_sequencer.sv
// Bench for rowbias_sequencer: cycle-level behavioural model compared every
// cycle, plus literal timing/LFSR expectations.
module tb_rowbias_sequencer;
  localparam int NR = 9;
  localparam int WD = 9;
  localparam int RW = 16;
  localparam int S  = 2*WD+2;
  localparam int BUSY_LEN = 1 + NR*S;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   failed = 0;

  rowbias_sequencer_if #(.NUM_ROWS(NR), .RAND_WIDTH(RW)) bus ();
  rowbias_sequencer #(.NUM_ROWS(NR), .WIDTH(WD), .RAND_WIDTH(RW)) dut (
    .clock(clock), .reset(reset), .bus(bus));

  initial forever #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] step(input logic [15:0] v);
    return (v >> 1) ^ (v[0] ? 16'hB400 : 16'h0000);
  endfunction

  // Model: m_pos counts cycles since the accepted start (0 = LOAD cycle).
  bit          m_active, m_ran;
  int          m_pos;
  logic [15:0] m_lfsr;

  // Behavioural model update on each clock edge.
  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_active = 0; m_ran = 0; m_pos = 0; m_lfsr = 16'hACE1;
    end else if (m_active) begin
      if (m_pos >= 1) m_lfsr = step(m_lfsr);
      m_pos++;
      if (m_pos == BUSY_LEN) begin m_active = 0; m_ran = 1; end
    end else if (bus.start) begin
      logic [15:0] v;
`ifdef ROWBIAS_SEQUENCER_FREERUN_EN
      v = m_lfsr ^ bus.seed;
`else
      v = bus.seed;
`endif
      m_lfsr = (v == 16'h0) ? 16'hACE1 : v;
      m_active = 1; m_pos = 0;
    end else begin
`ifdef ROWBIAS_SEQUENCER_FREERUN_EN
      m_lfsr = step(m_lfsr);
`endif
    end
  end

  // Per-cycle comparison of all outputs against the model.
  always @(negedge clock) begin
    logic [NR-1:0] e_rb;
    int r;
    if (m_active) begin
      if (m_pos == 0) e_rb = '1;
      else begin
        r = (m_pos - 1) / S;
        for (int j = 0; j < NR; j++) e_rb[j] = (j > r);
      end
    end else begin
      e_rb = m_ran ? '0 : '1;
    end
    chk("rb_reset", 32'(bus.rb_reset), 32'(e_rb));
    chk("busy", 32'(bus.busy), 32'(m_active));
    chk("done", 32'(bus.done), 32'(!m_active && m_ran));
    chk("random", 32'(bus.random), 32'(m_lfsr[RW-1:0]));
  end

  int busy_len, fall4, ones_cyc, done_cyc;
  logic [15:0] rnd [4];

  // Pulse start, then follow the sequence; optionally inject start at cyc 85
  // (row 4 in RELEASE). Bounded by 1000 cycles.
  task automatic run_seq(input logic [15:0] s, input bit inject);
    int cyc;
    logic prev;
    @(negedge clock); bus.start = 1'b1; bus.seed = s;
    @(negedge clock); bus.start = 1'b0; bus.seed = $urandom;
    cyc = 0; fall4 = -1; ones_cyc = 0; done_cyc = 0;
    while (bus.busy === 1'b1 && cyc < 1000) begin
      if (bus.rb_reset === '1) ones_cyc++;
      if (bus.done !== 1'b0) done_cyc++;
      if (cyc < 4) rnd[cyc] = bus.random;
      prev = bus.rb_reset[4];
      @(negedge clock);
      cyc++;
      if (inject && cyc == 85) begin bus.start = 1'b1; bus.seed = 16'h1234; end
      if (inject && cyc == 86) bus.start = 1'b0;
      if (prev && !bus.rb_reset[4]) fall4 = cyc;
    end
    busy_len = cyc;
  endtask

  initial begin
    bus.start = 1'b0;
    bus.seed  = 16'h0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    repeat (6) @(negedge clock);
    chk("idle_rb_reset", 32'(bus.rb_reset), 32'h1FF);
    chk("idle_busy", 32'(bus.busy), 0);
    chk("idle_done", 32'(bus.done), 0);
`ifndef ROWBIAS_SEQUENCER_FREERUN_EN
    chk("idle_random", 32'(bus.random), 32'hACE1);
`endif

    // seed 0 -> substitute value
    run_seq(16'h0000, 0);
    chk("seq0_busy_len", busy_len, BUSY_LEN);
    chk("seq0_row4_fall", fall4, 81);
    chk("seq0_done", 32'(bus.done), 1);
    chk("seq0_rb_zero", 32'(bus.rb_reset), 0);
    chk("seq0_ones_cycles", ones_cyc, 1);
`ifndef ROWBIAS_SEQUENCER_FREERUN_EN
    chk("seq0_rnd_load", 32'(rnd[0]), 32'hACE1);
`endif
    repeat (4) @(negedge clock);

    // golden LFSR sequence, restart from DONE
    run_seq(16'hACE1, 0);
`ifndef ROWBIAS_SEQUENCER_FREERUN_EN
    chk("lfsr_rel0", 32'(rnd[1]), 32'hACE1);
    chk("lfsr_rel1", 32'(rnd[2]), 32'hE270);
    chk("lfsr_rel2", 32'(rnd[3]), 32'h7138);
`endif
    chk("restart_ones_cycles", ones_cyc, 1);
    chk("restart_done_low", done_cyc, 0);
    chk("restart_busy_len", busy_len, BUSY_LEN);

    // start during row 4 ignored
    run_seq(16'h5A5A, 1);
    chk("inject_busy_len", busy_len, BUSY_LEN);
    chk("inject_row4_fall", fall4, 81);
    repeat (3) @(negedge clock);

    // async reset at row 6
    @(negedge clock); bus.start = 1'b1; bus.seed = 16'hBEEF;
    @(negedge clock); bus.start = 1'b0;
    repeat (1 + 6*S + 5) @(negedge clock);
    chk("row6_partial", 32'(bus.rb_reset), 32'h180);
    #2 reset = 1'b0;
    #1;
    chk("async_rb_reset", 32'(bus.rb_reset), 32'h1FF);
    chk("async_busy", 32'(bus.busy), 0);
    @(negedge clock); reset = 1'b1;
    repeat (2) @(negedge clock);
    run_seq(16'h0BAD, 0);
    chk("post_reset_busy_len", busy_len, BUSY_LEN);
    chk("post_reset_row4_fall", fall4, 81);

    // start held high: re-accepted on each DONE visit
    @(negedge clock); bus.start = 1'b1; bus.seed = 16'h4321;
    repeat (450) @(negedge clock);
    bus.start = 1'b0;
    repeat (200) @(negedge clock);

    // random start pulses and seeds
    for (int i = 0; i < 3000; i++) begin
      @(negedge clock);
      bus.start = ($urandom_range(0, 40) == 0);
      bus.seed  = ($urandom_range(0, 7) == 0) ? 16'h0 : 16'($urandom);
      if ($urandom_range(0, 1500) == 0) begin
        #2 reset = 1'b0;
        @(negedge clock); reset = 1'b1;
      end
    end
    bus.start = 1'b0;
    repeat (5) @(negedge clock);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
